video_timing_gen_prog: RTL and testbench
========================================

Name: video_timing_gen_prog

Overview:
Runtime-programmable successor to the fixed-mode video timing generator. Produces pixel/line counters, HSYNC/VSYNC with selectable polarity, active-display, new-frame and frame-count outputs. Timing and polarity are loaded through a valid/ready config port and applied only at a frame boundary, so mode switches (e.g. 720p to 480p) never produce a torn frame. Sits between the pixel clock domain root and the frame-buffer read / TMDS encoder pipeline.

Parameters:
H_W, 12, width of all horizontal fields and hcount_out
V_W, 11, width of all vertical fields and vcount_out
FC_W, 6, width of fc_out and cfg_fps_in
DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 1280/110/40/220, reset horizontal timing
DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 720/5/5/20, reset vertical timing
DEF_HS_POL / DEF_VS_POL, 1/1, reset sync polarity (1 = active-high)
DEF_FPS, 60, reset frame-count modulus

Ports:
pixel_clk_in  in  1  pixel clock, sole clock
rst_in  in  1  asynchronous, active-high reset
enable_in  in  1  1 = counters run; 0 = freeze
cfg_valid_in  in  1  config word valid
cfg_ready_out  out  1  block can accept a config word
cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in  in  H_W each  horizontal timing
cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in  in  V_W each  vertical timing
cfg_hs_pol_in, cfg_vs_pol_in  in  1 each  sync polarity
cfg_fps_in  in  FC_W  frame-count modulus
cfg_err_out  out  1  one-cycle pulse: accepted config rejected
hcount_out  out  H_W  current pixel
vcount_out  out  V_W  current line
hs_out, vs_out  out  1 each  sync, polarity applied
ad_out  out  1  active display
nf_out  out  1  new-frame pulse
fc_out  out  FC_W  frame counter

Behaviour:
- Reset (async assert, sync release): active config = DEF_*; pending empty; hcount/vcount/fc = 0; ad/nf/cfg_err = 0; hs_out = ~DEF_HS_POL, vs_out = ~DEF_VS_POL (inactive level); cfg_ready_out = 1.
- Derived from active config: HTOT = sum of h fields, VTOT = sum of v fields; sync window h in [ACT+FP, ACT+FP+SYNC), likewise v. Sums computed one bit wider than H_W/V_W.
- Counters (enable_in=1): hcount wraps at HTOT-1; vcount advances when hcount==HTOT-1, wraps at VTOT-1; fc advances when both at last value, wraps at fps-1; if fc_out >= fps-1 at that point it wraps to 0.
- Flags registered from the pre-increment count: hs/vs/ad/nf lag hcount/vcount by exactly one cycle. nf_out = 1 for one cycle following last pixel of frame.
- enable_in=0: counters and fc hold; ad_out and nf_out forced 0; hs/vs hold.
- Config handshake: transfer on cfg_valid_in & cfg_ready_out. Validation at acceptance: every field nonzero, fps nonzero, HTOT < 2^H_W, VTOT < 2^V_W. Invalid: cfg_err_out pulses next cycle, nothing stored, ready stays 1. Valid: stored in pending, cfg_ready_out = 0 next cycle.
- Apply: in the cycle hcount==HTOT-1 && vcount==VTOT-1 (enable_in=1) with pending full, active config <= pending, counters wrap to 0, fc wraps to 0; cfg_ready_out = 1 the following cycle. Polarity change takes effect in the same cycle as timing.
- Accept and apply never coincide (ready=0 while pending); a new word during apply cycle is impossible by construction.
- States: IDLE (ready=1), PENDING (ready=0) -> IDLE at apply. Reset mid-PENDING discards pending, restores DEF_*.

Optional Feature:
VTG_LINE_IRQ_EN: adds line_match_in (in, V_W) and line_irq_out (out, 1). line_irq_out pulses one cycle, aligned with the flags, for the count hcount==0 && vcount==line_match_in; reset 0; suppressed while enable_in=0. Without the macro, neither port exists and no logic is generated.

Test Plan:
- Reset release with DEF_*: hcount wraps 1649->0, vcount 749->0; hs_out high for hcount 1390..1429 (one-cycle lag); nf_out single pulse per 1650*750 cycles.
- Load h 8/2/2/2, v 4/1/1/1, pols 0/0, fps 3 mid-frame -> ready drops, old timing continues to frame end, then HTOT=14, VTOT=7; hs_out low for h 10..11; fc 0,1,2,0.
- Config with cfg_h_sync_in=0 -> cfg_err_out one-cycle pulse, cfg_ready_out stays 1, timing unchanged.
- enable_in low 20 cycles mid-line -> counters frozen, ad_out/nf_out 0; resume continues from same hcount.
- Assert rst_in while PENDING -> outputs reset immediately, DEF_* timing, ready=1, pending discarded.
- VTG_LINE_IRQ_EN with small mode, line_match_in=3 -> line_irq_out one pulse per frame, cycle after hcount=0,vcount=3.

Source files
------------

// File: rtl/video_timing_gen_prog.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_gen_prog
// Brief   : Runtime-programmable video timing generator. Config words arrive
//           on a valid/ready port and are switched in at a frame boundary.
//           Optional macro VTG_LINE_IRQ_EN adds a per-frame line-match pulse.
// Revision: 1.0 - initial release
// ============================================================================

module video_timing_gen_prog #(
  parameter int H_W          = 12,
  parameter int V_W          = 11,
  parameter int FC_W         = 6,
  parameter int DEF_H_ACTIVE = 1280,
  parameter int DEF_H_FP     = 110,
  parameter int DEF_H_SYNC   = 40,
  parameter int DEF_H_BP     = 220,
  parameter int DEF_V_ACTIVE = 720,
  parameter int DEF_V_FP     = 5,
  parameter int DEF_V_SYNC   = 5,
  parameter int DEF_V_BP     = 20,
  parameter bit DEF_HS_POL   = 1'b1,
  parameter bit DEF_VS_POL   = 1'b1,
  parameter int DEF_FPS      = 60
) (
  input  logic            pixel_clk_in,
  input  logic            rst_in,
  input  logic            enable_in,
  input  logic            cfg_valid_in,
  output logic            cfg_ready_out,
  input  logic [H_W-1:0]  cfg_h_active_in,
  input  logic [H_W-1:0]  cfg_h_fp_in,
  input  logic [H_W-1:0]  cfg_h_sync_in,
  input  logic [H_W-1:0]  cfg_h_bp_in,
  input  logic [V_W-1:0]  cfg_v_active_in,
  input  logic [V_W-1:0]  cfg_v_fp_in,
  input  logic [V_W-1:0]  cfg_v_sync_in,
  input  logic [V_W-1:0]  cfg_v_bp_in,
  input  logic            cfg_hs_pol_in,
  input  logic            cfg_vs_pol_in,
  input  logic [FC_W-1:0] cfg_fps_in,
  output logic            cfg_err_out,
  output logic [H_W-1:0]  hcount_out,
  output logic [V_W-1:0]  vcount_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            nf_out,
`ifdef VTG_LINE_IRQ_EN
  input  logic [V_W-1:0]  line_match_in,
  output logic            line_irq_out,
`endif
  output logic [FC_W-1:0] fc_out
);

  typedef struct packed {
    logic [H_W-1:0]  h_active;
    logic [H_W-1:0]  h_fp;
    logic [H_W-1:0]  h_sync;
    logic [H_W-1:0]  h_bp;
    logic [V_W-1:0]  v_active;
    logic [V_W-1:0]  v_fp;
    logic [V_W-1:0]  v_sync;
    logic [V_W-1:0]  v_bp;
    logic            hs_pol;
    logic            vs_pol;
    logic [FC_W-1:0] fps;
  } cfg_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam cfg_t C_DEF = '{
    h_active: H_W'(DEF_H_ACTIVE), h_fp: H_W'(DEF_H_FP),
    h_sync:   H_W'(DEF_H_SYNC),   h_bp: H_W'(DEF_H_BP),
    v_active: V_W'(DEF_V_ACTIVE), v_fp: V_W'(DEF_V_FP),
    v_sync:   V_W'(DEF_V_SYNC),   v_bp: V_W'(DEF_V_BP),
    hs_pol:   DEF_HS_POL,         vs_pol: DEF_VS_POL,
    fps:      FC_W'(DEF_FPS)
  };
  localparam logic [H_W:0]   C_H_ONE = (H_W+1)'(1);
  localparam logic [V_W:0]   C_V_ONE = (V_W+1)'(1);
  localparam logic [FC_W-1:0] C_FC_ONE = FC_W'(1);
  localparam logic [H_W+1:0] C_H_MAX = {2'b00, {H_W{1'b1}}};
  localparam logic [V_W+1:0] C_V_MAX = {2'b00, {V_W{1'b1}}};

  cfg_t   active, pending, cfg_in;
  state_t state, state_nxt;
  logic   cfg_ok, store, apply, reject;

  assign cfg_in = '{
    h_active: cfg_h_active_in, h_fp: cfg_h_fp_in,
    h_sync:   cfg_h_sync_in,   h_bp: cfg_h_bp_in,
    v_active: cfg_v_active_in, v_fp: cfg_v_fp_in,
    v_sync:   cfg_v_sync_in,   v_bp: cfg_v_bp_in,
    hs_pol:   cfg_hs_pol_in,   vs_pol: cfg_vs_pol_in,
    fps:      cfg_fps_in
  };

  // Totals of an incoming word carry two extra bits so four maximal fields cannot wrap.
  logic [H_W+1:0] new_h_tot;
  logic [V_W+1:0] new_v_tot;
  assign new_h_tot = (H_W+2)'(cfg_h_active_in) + (H_W+2)'(cfg_h_fp_in)
                   + (H_W+2)'(cfg_h_sync_in)   + (H_W+2)'(cfg_h_bp_in);
  assign new_v_tot = (V_W+2)'(cfg_v_active_in) + (V_W+2)'(cfg_v_fp_in)
                   + (V_W+2)'(cfg_v_sync_in)   + (V_W+2)'(cfg_v_bp_in);
  assign cfg_ok = (|cfg_h_active_in) & (|cfg_h_fp_in) & (|cfg_h_sync_in) & (|cfg_h_bp_in)
                & (|cfg_v_active_in) & (|cfg_v_fp_in) & (|cfg_v_sync_in) & (|cfg_v_bp_in)
                & (|cfg_fps_in) & (new_h_tot <= C_H_MAX) & (new_v_tot <= C_V_MAX);

  // Window edges and totals of the active mode.
  logic [H_W:0] hs_start, hs_end, h_tot, h_last;
  logic [V_W:0] vs_start, vs_end, v_tot, v_last;
  assign hs_start = {1'b0, active.h_active} + {1'b0, active.h_fp};
  assign hs_end   = hs_start + {1'b0, active.h_sync};
  assign h_tot    = hs_end + {1'b0, active.h_bp};
  assign h_last   = h_tot - C_H_ONE;
  assign vs_start = {1'b0, active.v_active} + {1'b0, active.v_fp};
  assign vs_end   = vs_start + {1'b0, active.v_sync};
  assign v_tot    = vs_end + {1'b0, active.v_bp};
  assign v_last   = v_tot - C_V_ONE;

  logic at_h_last, at_v_last, frame_end, in_hs, in_vs, in_ad;
  logic [FC_W-1:0] fc_last;
  assign at_h_last = ({1'b0, hcount_out} == h_last);
  assign at_v_last = ({1'b0, vcount_out} == v_last);
  assign frame_end = at_h_last & at_v_last;
  assign in_hs     = ({1'b0, hcount_out} >= hs_start) && ({1'b0, hcount_out} < hs_end);
  assign in_vs     = ({1'b0, vcount_out} >= vs_start) && ({1'b0, vcount_out} < vs_end);
  assign in_ad     = (hcount_out < active.h_active) && (vcount_out < active.v_active);
  assign fc_last   = active.fps - C_FC_ONE;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cfg_ready_out = 1'b0;
    store         = 1'b0;
    apply         = 1'b0;
    reject        = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready_out = 1'b1;
        if (cfg_valid_in) begin
          store  = cfg_ok;
          reject = ~cfg_ok;
          if (cfg_ok) state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (enable_in && frame_end) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)     pending <= C_DEF;
    else if (store) pending <= cfg_in;
  end

  // Flags are taken from the count being left, so they trail the counters by one cycle.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      active      <= C_DEF;
      hcount_out  <= '0;
      vcount_out  <= '0;
      fc_out      <= '0;
      hs_out      <= ~DEF_HS_POL;
      vs_out      <= ~DEF_VS_POL;
      ad_out      <= 1'b0;
      nf_out      <= 1'b0;
      cfg_err_out <= 1'b0;
    end else begin
      cfg_err_out <= reject;
      if (enable_in) begin
        hs_out <= ~(in_hs ^ active.hs_pol);
        vs_out <= ~(in_vs ^ active.vs_pol);
        ad_out <= in_ad;
        nf_out <= frame_end;
        if (at_h_last) begin
          hcount_out <= '0;
          if (at_v_last) begin
            vcount_out <= '0;
            if (apply) begin
              active <= pending;
              fc_out <= '0;
            end else if (fc_out >= fc_last) begin
              fc_out <= '0;
            end else begin
              fc_out <= fc_out + 1'b1;
            end
          end else begin
            vcount_out <= vcount_out + 1'b1;
          end
        end else begin
          hcount_out <= hcount_out + 1'b1;
        end
      end else begin
        ad_out <= 1'b0;
        nf_out <= 1'b0;
      end
    end
  end

`ifdef VTG_LINE_IRQ_EN
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) line_irq_out <= 1'b0;
    else        line_irq_out <= enable_in && (hcount_out == '0) && (vcount_out == line_match_in);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen_prog.sv
`default_nettype none
// Bench for video_timing_gen_prog: a small-default instance checked every cycle
// against a frame-position model, plus a stock 720p instance pinned by literals.

module tb_video_timing_gen_prog;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int fps;
  } vcfg_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        en = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [11:0] c_ha = '0, c_hf = '0, c_hs = '0, c_hb = '0;
  logic [10:0] c_va = '0, c_vf = '0, c_vs = '0, c_vb = '0;
  logic        c_hp = 1'b0, c_vp = 1'b0;
  logic [5:0]  c_fps = '0;
  logic [10:0] line_match = 11'd3;

  logic        s_ready, s_err, s_hs, s_vs, s_ad, s_nf;
  logic [11:0] s_h;
  logic [10:0] s_v;
  logic [5:0]  s_fc;
  logic        d_ready, d_err, d_hs, d_vs, d_ad, d_nf;
  logic [11:0] d_h;
  logic [10:0] d_v;
  logic [5:0]  d_fc;
`ifdef VTG_LINE_IRQ_EN
  logic        s_irq, d_irq;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  initial forever #5 clk = ~clk;

  video_timing_gen_prog #(
    .DEF_H_ACTIVE(10), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(5),
    .DEF_V_ACTIVE(6),  .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(3),
    .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1), .DEF_FPS(4)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst_in), .enable_in(en),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(s_ready),
    .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
    .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
    .cfg_hs_pol_in(c_hp), .cfg_vs_pol_in(c_vp), .cfg_fps_in(c_fps),
    .cfg_err_out(s_err), .hcount_out(s_h), .vcount_out(s_v),
    .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf),
`ifdef VTG_LINE_IRQ_EN
    .line_match_in(line_match), .line_irq_out(s_irq),
`endif
    .fc_out(s_fc)
  );

  video_timing_gen_prog dut_def (
    .pixel_clk_in(clk), .rst_in(rst_in), .enable_in(1'b1),
    .cfg_valid_in(1'b0), .cfg_ready_out(d_ready),
    .cfg_h_active_in('0), .cfg_h_fp_in('0), .cfg_h_sync_in('0), .cfg_h_bp_in('0),
    .cfg_v_active_in('0), .cfg_v_fp_in('0), .cfg_v_sync_in('0), .cfg_v_bp_in('0),
    .cfg_hs_pol_in(1'b0), .cfg_vs_pol_in(1'b0), .cfg_fps_in('0),
    .cfg_err_out(d_err), .hcount_out(d_h), .vcount_out(d_v),
    .hs_out(d_hs), .vs_out(d_vs), .ad_out(d_ad), .nf_out(d_nf),
`ifdef VTG_LINE_IRQ_EN
    .line_match_in(line_match), .line_irq_out(d_irq),
`endif
    .fc_out(d_fc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vcfg_t def_cfg();
    vcfg_t c = '{10, 2, 3, 5, 6, 1, 2, 3, 1'b1, 1'b1, 4};
    return c;
  endfunction

  function automatic int htot(input vcfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int vtot(input vcfg_t c);
    return c.va + c.vf + c.vs + c.vb;
  endfunction

  function automatic bit cfg_ok(input vcfg_t c);
    return c.ha > 0 && c.hf > 0 && c.hs > 0 && c.hb > 0 &&
           c.va > 0 && c.vf > 0 && c.vs > 0 && c.vb > 0 &&
           c.fps > 0 && htot(c) < 4096 && vtot(c) < 2048;
  endfunction

  function automatic vcfg_t cur_in();
    vcfg_t c;
    c.ha = int'(c_ha); c.hf = int'(c_hf); c.hs = int'(c_hs); c.hb = int'(c_hb);
    c.va = int'(c_va); c.vf = int'(c_vf); c.vs = int'(c_vs); c.vb = int'(c_vb);
    c.hp = c_hp; c.vp = c_vp; c.fps = int'(c_fps);
    return c;
  endfunction

  // Model: position within the frame as one linear pixel index.
  vcfg_t m_cfg, m_pend;
  bit    m_full, m_wasfull;
  int    m_p, m_fc, m_ht, m_tot, m_h, m_v;
  bit    e_hs, e_vs, e_ad, e_nf, e_err, e_irq, m_inh, m_inv;

  task model_step();
    if (rst_in) begin
      m_cfg = def_cfg(); m_full = 1'b0; m_p = 0; m_fc = 0;
      e_hs = !m_cfg.hp; e_vs = !m_cfg.vp;
      e_ad = 1'b0; e_nf = 1'b0; e_err = 1'b0; e_irq = 1'b0;
    end else begin
      m_wasfull = m_full;
      e_err = 1'b0;
      if (!m_wasfull && cfg_valid) begin
        if (cfg_ok(cur_in())) begin
          m_pend = cur_in();
          m_full = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
      if (en) begin
        m_ht  = htot(m_cfg);
        m_tot = m_ht * vtot(m_cfg);
        m_h   = m_p % m_ht;
        m_v   = m_p / m_ht;
        m_inh = m_h >= m_cfg.ha + m_cfg.hf && m_h < m_cfg.ha + m_cfg.hf + m_cfg.hs;
        m_inv = m_v >= m_cfg.va + m_cfg.vf && m_v < m_cfg.va + m_cfg.vf + m_cfg.vs;
        e_hs  = m_cfg.hp ? m_inh : !m_inh;
        e_vs  = m_cfg.vp ? m_inv : !m_inv;
        e_ad  = m_h < m_cfg.ha && m_v < m_cfg.va;
        e_nf  = m_p == m_tot - 1;
        e_irq = m_h == 0 && m_v == int'(line_match);
        if (m_p == m_tot - 1) begin
          m_p = 0;
          if (m_wasfull) begin
            m_cfg = m_pend; m_full = 1'b0; m_fc = 0;
          end else begin
            m_fc = (m_fc >= m_cfg.fps - 1) ? 0 : m_fc + 1;
          end
        end else begin
          m_p++;
        end
      end else begin
        e_ad = 1'b0; e_nf = 1'b0; e_irq = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst_in);
    model_step();
  end

  int cmp_ht;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_ht = htot(m_cfg);
      chk("hcount", s_h, m_p % cmp_ht);
      chk("vcount", s_v, m_p / cmp_ht);
      chk("hs", s_hs, e_hs);
      chk("vs", s_vs, e_vs);
      chk("ad", s_ad, e_ad);
      chk("nf", s_nf, e_nf);
      chk("fc", s_fc, m_fc);
      chk("ready", s_ready, !m_full);
      chk("err", s_err, e_err);
`ifdef VTG_LINE_IRQ_EN
      chk("line_irq", s_irq, e_irq);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cfg(input vcfg_t c);
    c_ha = 12'(c.ha); c_hf = 12'(c.hf); c_hs = 12'(c.hs); c_hb = 12'(c.hb);
    c_va = 11'(c.va); c_vf = 11'(c.vf); c_vs = 11'(c.vs); c_vb = 11'(c.vb);
    c_hp = c.hp; c_vp = c.vp; c_fps = 6'(c.fps);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_small(input int h, input int v, input int budget, input string name);
    int n = 0;
    while (!(int'(s_h) == h && int'(s_v) == v) && n < budget) begin
      tick();
      n++;
    end
    chk(name, n < budget, 1'b1);
  endtask

  task automatic wait_def(input int h, input int budget, input string name);
    int n = 0;
    while (int'(d_h) != h && n < budget) begin
      tick();
      n++;
    end
    chk(name, n < budget, 1'b1);
  endtask

  task automatic wait_nf(input int budget, input string name);
    int n = 0;
    while (s_nf !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, n < budget, 1'b1);
  endtask

  vcfg_t small_mode = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 3};
  vcfg_t big_mode   = '{4000, 50, 40, 5, 4, 1, 1, 1, 1'b1, 1'b1, 5};
  vcfg_t bad[4];
  int    fc_exp[2] = '{2, 0};

  initial begin
    bad[0] = '{8, 2, 0, 2, 4, 1, 1, 1, 1'b0, 1'b0, 3};
    bad[1] = '{4000, 50, 40, 6, 4, 1, 1, 1, 1'b0, 1'b0, 3};
    bad[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 0};
    bad[3] = '{8, 2, 2, 2, 2000, 20, 20, 8, 1'b0, 1'b0, 3};

    tick(3);
    chk_en = 1'b1;
    chk("rst_hs_small", s_hs, 1'b0);
    chk("rst_ready_small", s_ready, 1'b1);
    chk("rst_hs_def", d_hs, 1'b0);
    chk("rst_vs_def", d_vs, 1'b0);
    chk("rst_ready_def", d_ready, 1'b1);
    chk("rst_h_def", d_h, 0);
    rst_in = 1'b0;
    tick();
    chk("first_inc_small", s_h, 1);
    chk("first_inc_def", d_h, 1);

    // Stock 720p mode: sync window 1390..1429 seen one cycle late.
    wait_def(1389, 2000, "def_reach_1389");
    chk("def_hs_1389", d_hs, 1'b0);
    tick();
    chk("def_hs_1390", d_hs, 1'b0);
    tick();
    chk("def_hs_1391", d_hs, 1'b1);
    wait_def(1430, 100, "def_reach_1430");
    chk("def_hs_1430", d_hs, 1'b1);
    tick();
    chk("def_hs_1431", d_hs, 1'b0);
    wait_def(1649, 300, "def_reach_1649");
    chk("def_v_line0", d_v, 0);
    tick();
    chk("def_h_wrap", d_h, 0);
    chk("def_v_inc", d_v, 1);
    chk("def_ad_blank", d_ad, 1'b0);
    tick();
    chk("def_ad_active", d_ad, 1'b1);
    chk("def_nf", d_nf, 1'b0);

    // Mid-frame mode load: old 20x12 frame must finish before 14x7 starts.
    wait_small(5, 2, 600, "load_reach");
    send_cfg(small_mode);
    chk("load_ready_low", s_ready, 1'b0);
    wait_small(19, 11, 300, "old_frame_end");
    chk("old_end_ready", s_ready, 1'b0);
    tick();
    chk("apply_h", s_h, 0);
    chk("apply_v", s_v, 0);
    chk("apply_ready", s_ready, 1'b1);
    chk("apply_fc", s_fc, 0);
    chk("apply_nf", s_nf, 1'b1);
    wait_small(13, 0, 20, "new_line_end");
    tick();
    chk("new_h_wrap", s_h, 0);
    chk("new_v_inc", s_v, 1);
    wait_small(10, 1, 20, "new_hs_reach");
    chk("new_hs_10", s_hs, 1'b1);
    tick();
    chk("new_hs_11", s_hs, 1'b0);
    tick();
    chk("new_hs_12", s_hs, 1'b0);
    tick();
    chk("new_hs_13", s_hs, 1'b1);
    wait_small(13, 6, 100, "new_frame_end");
    tick();
    chk("new_v_wrap", s_v, 0);
    chk("new_fc1", s_fc, 1);
    chk("new_nf", s_nf, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      wait_nf(150, "nf_reach");
      chk("fc_seq", s_fc, fc_exp[i]);
    end

    // Rejected words: bad field, width overflow, zero fps.
    for (int i = 0; i < 4; i++) begin
      send_cfg(bad[i]);
      chk("bad_err", s_err, 1'b1);
      chk("bad_ready", s_ready, 1'b1);
      tick();
      chk("bad_err_clear", s_err, 1'b0);
    end

    // Freeze mid-line.
    wait_small(5, 3, 200, "freeze_reach");
    en = 1'b0;
    tick(20);
    chk("freeze_h", s_h, 5);
    chk("freeze_v", s_v, 3);
    chk("freeze_ad", s_ad, 1'b0);
    chk("freeze_nf", s_nf, 1'b0);
    en = 1'b1;
    tick();
    chk("resume_h", s_h, 6);

    // Boundary-width word accepted, then discarded by reset while pending.
    send_cfg(big_mode);
    chk("big_ready_low", s_ready, 1'b0);
    chk("big_err", s_err, 1'b0);
    tick(5);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_h", s_h, 0);
    chk("mid_rst_ready", s_ready, 1'b1);
    chk("mid_rst_hs", s_hs, 1'b0);
    chk("mid_rst_fc", s_fc, 0);
    tick(2);
    rst_in = 1'b0;
    wait_small(19, 0, 40, "def_line_end");
    tick();
    chk("def_h_wrap_small", s_h, 0);
    chk("def_v_inc_small", s_v, 1);
    wait_small(19, 11, 300, "def_frame_end");
    tick();
    chk("def_frame_nf", s_nf, 1'b1);
    chk("def_frame_v", s_v, 0);
    chk("def_frame_fc", s_fc, 1);

`ifdef VTG_LINE_IRQ_EN
    wait_small(0, 3, 300, "irq_reach");
    tick();
    chk("irq_pulse", s_irq, 1'b1);
    tick();
    chk("irq_clear", s_irq, 1'b0);
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
